// File: rtl/comparador_estimulo_verificador.sv
// Self-checking stimulus driver for a sequential magnitude comparator.
// Issues operand pairs, predicts eq/lt, and counts mismatches after the comparator latency.
`timescale 1ns/1ps
module comparador_estimulo_verificador #(
  parameter int WIDTH     = 8,
  parameter int LATENCY   = 1,
  parameter int N_VECTORS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q,
  input  logic             q_lt,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count
);

  // One extra stage covers the operand register, so a LATENCY-stage comparator
  // result is sampled in the cycle it becomes valid.
  localparam int          DEPTH      = LATENCY + 1;
  localparam logic [15:0] LAST_IDX   = 16'(N_VECTORS - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'(LATENCY);
  localparam bit          SINGLE_VEC = (N_VECTORS == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] vec_a(input logic [15:0] c);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = (i < 16) ? c[i[3:0]] : 1'b0;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] vec_b(input logic [15:0] c);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] r;
    a = vec_a(c);
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = a[WIDTH-1-i];
    end
    if (c[1:0] == 2'b11) begin
      r = a;
    end else begin
      r = r;
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         drain_q, drain_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [15:0]        err_q, err_d;
  logic [15:0]        vec_q, vec_d;
  logic [DEPTH-1:0]   pipe_v_q, pipe_v_d;
  logic [DEPTH-1:0]   pipe_eq_q, pipe_eq_d;
  logic [DEPTH-1:0]   pipe_lt_q, pipe_lt_d;

  logic               push_s;
  logic               mismatch_s;
  logic [15:0]        ld_idx_s;
  logic [WIDTH-1:0]   ld_a_s;
  logic [WIDTH-1:0]   ld_b_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      drain_q   <= 4'd0;
      a_q       <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= 16'd0;
      vec_q     <= 16'd0;
      pipe_v_q  <= '0;
      pipe_eq_q <= '0;
      pipe_lt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_q     <= err_d;
      vec_q     <= vec_d;
      pipe_v_q  <= pipe_v_d;
      pipe_eq_q <= pipe_eq_d;
      pipe_lt_q <= pipe_lt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    err_d    = err_q;
    vec_d    = vec_q;
    push_s   = 1'b0;

    ld_idx_s = (state_q == S_IDLE) ? 16'd0 : (cnt_q + 16'd1);
    ld_a_s   = vec_a(ld_idx_s);
    ld_b_s   = vec_b(ld_idx_s);

    mismatch_s = pipe_v_q[DEPTH-1] &&
                 ((q != pipe_eq_q[DEPTH-1]) || (q_lt != pipe_lt_q[DEPTH-1]));
    if (mismatch_s) begin
      error_d = 1'b1;
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end else begin
        err_d = err_q;
      end
    end else begin
      error_d = error_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = 16'd0;
          drain_d = 4'd0;
          err_d   = 16'd0;
          error_d = 1'b0;
          vec_d   = 16'd0;
          busy_d  = 1'b1;
          a_d     = ld_a_s;
          b_d     = ld_b_s;
          push_s  = 1'b1;
          state_d = SINGLE_VEC ? S_DRAIN : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d  = ld_idx_s;
        a_d    = ld_a_s;
        b_d    = ld_b_s;
        push_s = 1'b1;
        vec_d  = vec_q + 16'd1;
        if (ld_idx_s == LAST_IDX) begin
          drain_d = 4'd0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // The last vector is counted once its first presentation cycle ends.
        if (drain_q == 4'd0) begin
          vec_d = vec_q + 16'd1;
        end else begin
          vec_d = vec_q;
        end
        if (drain_q == DRAIN_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pipe_v_d  = {pipe_v_q[DEPTH-2:0], push_s};
    pipe_eq_d = {pipe_eq_q[DEPTH-2:0], push_s && (ld_a_s == ld_b_s)};
    pipe_lt_d = {pipe_lt_q[DEPTH-2:0], push_s && (ld_a_s < ld_b_s)};
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_comparador_estimulo_verificador.sv
// Directed bench: two driver instances against small comparator models with
// selectable latency and injected comparator faults.
`timescale 1ns/1ps
module tb_comparador_estimulo_verificador;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start3;
  logic        q1, lt1, q3, lt3;
  logic [7:0]  a1, b1, a3, b3;
  logic        busy1, done1, error1, busy3, done3, error3;
  logic [15:0] errc1, vecc1, errc3, vecc3;

  int fault1     = 0;  // 0 good, 1 q stuck at 0, 2 q_lt inverted
  int one_stage3 = 0;
  int n_chk      = 0;
  int n_err      = 0;

  logic [2:0] eq1_p = 3'd0, lt1_p = 3'd0, eq3_p = 3'd0, lt3_p = 3'd0;

  always #5 clk = ~clk;

  // comparator models: three register stages, tap 1 or 3
  always_ff @(posedge clk) begin
    eq1_p <= {eq1_p[1:0], a1 == b1};
    lt1_p <= {lt1_p[1:0], a1 < b1};
    eq3_p <= {eq3_p[1:0], a3 == b3};
    lt3_p <= {lt3_p[1:0], a3 < b3};
  end

  assign q1  = (fault1 == 1) ? 1'b0 : eq1_p[0];
  assign lt1 = (fault1 == 2) ? ~lt1_p[0] : lt1_p[0];
  assign q3  = (one_stage3 != 0) ? eq3_p[0] : eq3_p[2];
  assign lt3 = (one_stage3 != 0) ? lt3_p[0] : lt3_p[2];

  comparador_estimulo_verificador #(.WIDTH(8), .LATENCY(1), .N_VECTORS(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .q(q1), .q_lt(lt1),
    .A(a1), .B(b1), .busy(busy1), .done(done1), .error(error1),
    .err_count(errc1), .vec_count(vecc1)
  );

  comparador_estimulo_verificador #(.WIDTH(8), .LATENCY(3), .N_VECTORS(8)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .q(q3), .q_lt(lt3),
    .A(a3), .B(b3), .busy(busy3), .done(done3), .error(error3),
    .err_count(errc3), .vec_count(vecc3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse start1; returns at the negedge right after the accepting edge (count 1).
  task automatic pulse1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic wait_done1(inout int cyc);
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run1(output int cyc);
    pulse1();
    cyc = 1;
    wait_done1(cyc);
  endtask

  task automatic run3(output int cyc);
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    cyc = 1;
    while (!done3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int ndone;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_A", a1, 8'h00);
    check("rst_B", b1, 8'h00);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_error", error1, 1'b0);
    check("rst_err", errc1, 16'd0);
    check("rst_vec", vecc1, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // good comparator: operand sequence and done latency
    pulse1();
    check("v0_A", a1, 8'h00); check("v0_B", b1, 8'h00);
    check("v0_busy", busy1, 1'b1);
    @(negedge clk); check("v1_A", a1, 8'h01); check("v1_B", b1, 8'h80);
    @(negedge clk); check("v2_A", a1, 8'h02); check("v2_B", b1, 8'h40);
    @(negedge clk); check("v3_A", a1, 8'h03); check("v3_B", b1, 8'h03);
    cyc = 4;
    wait_done1(cyc);
    check("good_done_lat", cyc, 18);
    check("good_err", errc1, 16'd0);
    check("good_error", error1, 1'b0);
    check("good_vec", vecc1, 16'd16);
    check("good_busy_at_done", busy1, 1'b0);
    check("good_last_A", a1, 8'h0F);
    check("good_last_B", b1, 8'h0F);
    @(negedge clk);
    check("done_one_cycle", done1, 1'b0);

    // q stuck at 0: equal vectors 0,3,7,11,15 fail
    fault1 = 1;
    run1(cyc);
    check("qs0_done_lat", cyc, 18);
    check("qs0_err", errc1, 16'd5);
    check("qs0_error", error1, 1'b1);
    check("qs0_vec", vecc1, 16'd16);

    // q_lt inverted: every vector fails
    fault1 = 2;
    run1(cyc);
    check("ltinv_err", errc1, 16'd16);
    check("ltinv_error", error1, 1'b1);

    // start re-pulsed at vector 5 must be ignored
    fault1 = 0;
    pulse1();
    check("restart_err_clr", errc1, 16'd0);
    check("restart_error_clr", error1, 1'b0);
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done1) ndone++;
      start1 = (a1 == 8'h05);
      @(negedge clk);
    end
    start1 = 1'b0;
    check("busy_start_done_cnt", ndone, 1);
    check("busy_start_vec", vecc1, 16'd16);
    check("busy_start_err", errc1, 16'd0);

    // reset mid-run at vector 7 (faulty model so err_count is non-zero first)
    fault1 = 1;
    pulse1();
    for (int c = 1; c < 20 && a1 != 8'h07; c++) @(negedge clk);
    check("abort_reached_v7", a1, 8'h07);
    check("abort_err_before", errc1, 16'd2);
    rst = 1'b1;
    #1;
    check("abort_A", a1, 8'h00);
    check("abort_B", b1, 8'h00);
    check("abort_busy", busy1, 1'b0);
    check("abort_err", errc1, 16'd0);
    check("abort_error", error1, 1'b0);
    check("abort_vec", vecc1, 16'd0);
    @(negedge clk) rst = 1'b0;
    fault1 = 0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run1(cyc);
    check("after_abort_lat", cyc, 18);
    check("after_abort_err", errc1, 16'd0);
    check("after_abort_vec", vecc1, 16'd16);

    // LATENCY=3 with matching 3-stage model
    one_stage3 = 0;
    run3(cyc);
    check("l3_done_lat", cyc, 12);
    check("l3_err", errc3, 16'd0);
    check("l3_error", error3, 1'b0);
    check("l3_vec", vecc3, 16'd8);

    // LATENCY=3 against a 1-stage model: vectors 0,1,3,5,6 mismatch
    one_stage3 = 1;
    run3(cyc);
    check("l3_short_err", errc3, 16'd5);
    check("l3_short_error", error3, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
